// File: rtl/conv_pkg.sv
// Shared types and constants for the CONV command scheduler.
package conv_pkg;

  localparam int unsigned IMG_LOG2_DEF = 6;
  localparam int unsigned IMG_SIDE     = 64;
  localparam int unsigned ADDR_W_DEF   = 12;
  localparam int unsigned TAP_CNT      = 9;
  localparam int unsigned POOL_RD_CNT  = 4;
  localparam int unsigned TAP_W        = 4;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [1:0] {
    OP_IMG_TAP = 2'd0,
    OP_WR_L0   = 2'd1,
    OP_RD_L0   = 2'd2,
    OP_WR_L1   = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONV_TAP = 3'd1,
    ST_CONV_WR  = 3'd2,
    ST_POOL_RD  = 3'd3,
    ST_POOL_WR  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // 3x3 window offsets, row-major: tap k -> dy = k/3-1, dx = k%3-1
  localparam logic signed [1:0] TAP_DX [TAP_CNT] = '{
    2'sb11, 2'sb00, 2'sb01,
    2'sb11, 2'sb00, 2'sb01,
    2'sb11, 2'sb00, 2'sb01
  };
  localparam logic signed [1:0] TAP_DY [TAP_CNT] = '{
    2'sb11, 2'sb11, 2'sb11,
    2'sb00, 2'sb00, 2'sb00,
    2'sb01, 2'sb01, 2'sb01
  };

endpackage

// File: rtl/conv_win_addr.sv
// Image-tap address generator: maps (x, y, tap) to a padded image address.
module conv_win_addr
  import conv_pkg::*;
#(
  parameter int unsigned IMG_LOG2 = IMG_LOG2_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic [IMG_LOG2-1:0] x,
  input  logic [IMG_LOG2-1:0] y,
  input  logic [TAP_W-1:0]    tap,
  output logic [ADDR_W-1:0]   addr,
  output logic                pad,
  output logic                last
);

  // One extra bit so that -1 and SIDE both land with the top bit set
  localparam int unsigned SW = IMG_LOG2 + 1;

  logic [TAP_W-1:0]     tap_idx;
  logic signed [1:0]    dx;
  logic signed [1:0]    dy;
  logic signed [SW-1:0] px;
  logic signed [SW-1:0] py;

  // Neighbour coordinate, out-of-image detection and final tap flag
  always_comb begin
    tap_idx = (tap < TAP_W'(TAP_CNT)) ? tap : '0;
    dx      = TAP_DX[tap_idx];
    dy      = TAP_DY[tap_idx];
    px      = $signed({1'b0, x}) + SW'(dx);
    py      = $signed({1'b0, y}) + SW'(dy);
    pad     = px[SW-1] | py[SW-1];
    addr    = pad ? '0 : ADDR_W'({py[IMG_LOG2-1:0], px[IMG_LOG2-1:0]});
    last    = (tap == TAP_W'(TAP_CNT - 1));
  end

endmodule

// File: rtl/conv_sched.sv
// CONV flow command scheduler: conv taps/writes then pool reads/writes over one valid/ready stream.
module conv_sched
  import conv_pkg::*;
#(
  parameter int unsigned IMG_LOG2 = IMG_LOG2_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_pad,
  output logic              cmd_last,
  output logic [2:0]        csel
);

  localparam logic [IMG_LOG2-1:0] X_MAX    = '1;
  localparam logic [IMG_LOG2-1:0] POOL_MAX = X_MAX - IMG_LOG2'(1);
  localparam logic [TAP_W-1:0]    TAP_LAST = TAP_W'(TAP_CNT - 1);
  localparam logic [TAP_W-1:0]    RD_LAST  = TAP_W'(POOL_RD_CNT - 1);

  state_e              state_q;
  state_e              nxt_state;
  logic [IMG_LOG2-1:0] x_q;
  logic [IMG_LOG2-1:0] y_q;
  logic [TAP_W-1:0]    tap_q;
  logic [IMG_LOG2-1:0] nx;
  logic [IMG_LOG2-1:0] ny;
  logic [TAP_W-1:0]    ntap;
  logic                xfer;

  logic [ADDR_W-1:0]   win_addr;
  logic                win_pad;
  logic                win_last;
  logic [IMG_LOG2-1:0] rd_x;
  logic [IMG_LOG2-1:0] rd_y;

  cmd_op_e             n_op;
  logic [ADDR_W-1:0]   n_addr;
  logic                n_pad;
  logic                n_last;
  logic [2:0]          n_csel;
  logic                n_valid;
  logic                n_busy;

  assign xfer = cmd_valid & cmd_ready;

  // Next state and counters; counters only move on an accepted command
  always_comb begin
    nxt_state = state_q;
    nx        = x_q;
    ny        = y_q;
    ntap      = tap_q;
    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          nxt_state = ST_CONV_TAP;
          nx        = '0;
          ny        = '0;
          ntap      = '0;
        end
      end
      ST_CONV_TAP: begin
        if (xfer) begin
          if (tap_q == TAP_LAST) begin
            nxt_state = ST_CONV_WR;
            ntap      = '0;
          end else begin
            ntap = tap_q + TAP_W'(1);
          end
        end
      end
      ST_CONV_WR: begin
        if (xfer) begin
          ntap = '0;
          if ((x_q == X_MAX) && (y_q == X_MAX)) begin
            nxt_state = ST_POOL_RD;
            nx        = '0;
            ny        = '0;
          end else begin
            nxt_state = ST_CONV_TAP;
            nx        = x_q + IMG_LOG2'(1);
            if (x_q == X_MAX) ny = y_q + IMG_LOG2'(1);
          end
        end
      end
      ST_POOL_RD: begin
        if (xfer) begin
          if (tap_q == RD_LAST) begin
            nxt_state = ST_POOL_WR;
            ntap      = '0;
          end else begin
            ntap = tap_q + TAP_W'(1);
          end
        end
      end
      ST_POOL_WR: begin
        if (xfer) begin
          ntap = '0;
          if ((x_q == POOL_MAX) && (y_q == POOL_MAX)) begin
            nxt_state = ST_DONE;
            nx        = '0;
            ny        = '0;
          end else begin
            nxt_state = ST_POOL_RD;
            nx        = x_q + IMG_LOG2'(2);
            if (x_q == POOL_MAX) ny = y_q + IMG_LOG2'(2);
          end
        end
      end
      ST_DONE: begin
        nxt_state = ST_IDLE;
        nx        = '0;
        ny        = '0;
        ntap      = '0;
      end
      default: begin
        nxt_state = ST_IDLE;
        nx        = '0;
        ny        = '0;
        ntap      = '0;
      end
    endcase
  end

  conv_win_addr #(
    .IMG_LOG2 (IMG_LOG2),
    .ADDR_W   (ADDR_W)
  ) u_win (
    .x    (nx),
    .y    (ny),
    .tap  (ntap),
    .addr (win_addr),
    .pad  (win_pad),
    .last (win_last)
  );

  // Pool read offsets within the 2x2 block: bit0 -> +x, bit1 -> +y
  assign rd_x = nx + IMG_LOG2'(ntap[0]);
  assign rd_y = ny + IMG_LOG2'(ntap[1]);

  // Command for the upcoming state; held unchanged while stalled since next == current
  always_comb begin
    n_op    = OP_IMG_TAP;
    n_addr  = '0;
    n_pad   = 1'b0;
    n_last  = 1'b0;
    n_csel  = CSEL_NONE;
    n_valid = 1'b0;
    n_busy  = 1'b0;
    case (nxt_state)
      ST_CONV_TAP: begin
        n_valid = 1'b1;
        n_busy  = 1'b1;
        n_addr  = win_addr;
        n_pad   = win_pad;
        n_last  = win_last;
      end
      ST_CONV_WR: begin
        n_valid = 1'b1;
        n_busy  = 1'b1;
        n_op    = OP_WR_L0;
        n_addr  = ADDR_W'({ny, nx});
        n_csel  = CSEL_L0;
      end
      ST_POOL_RD: begin
        n_valid = 1'b1;
        n_busy  = 1'b1;
        n_op    = OP_RD_L0;
        n_addr  = ADDR_W'({rd_y, rd_x});
        n_last  = (ntap == RD_LAST);
        n_csel  = CSEL_L0;
      end
      ST_POOL_WR: begin
        n_valid = 1'b1;
        n_busy  = 1'b1;
        n_op    = OP_WR_L1;
        n_addr  = ADDR_W'({ny[IMG_LOG2-1:1], nx[IMG_LOG2-1:1]});
        n_csel  = CSEL_L1;
      end
      default: ;
    endcase
  end

  // State, counters and registered command outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      tap_q     <= '0;
      busy      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= 2'd0;
      cmd_addr  <= '0;
      cmd_pad   <= 1'b0;
      cmd_last  <= 1'b0;
      csel      <= CSEL_NONE;
    end else begin
      state_q   <= nxt_state;
      x_q       <= nx;
      y_q       <= ny;
      tap_q     <= ntap;
      busy      <= n_busy;
      cmd_valid <= n_valid;
      cmd_op    <= n_op;
      cmd_addr  <= n_addr;
      cmd_pad   <= n_pad;
      cmd_last  <= n_last;
      csel      <= n_csel;
    end
  end

endmodule

// File: tb/tb_conv_sched.sv
// Scoreboard bench for conv_sched: reference command list, backpressure, reset abort, restart.
module tb_conv_sched;

  localparam int unsigned ADDR_W = 12;
  localparam int          N_CMDS = 46080;

  typedef struct packed {
    logic [1:0]  op;
    logic [11:0] addr;
    logic        pad;
    logic        last;
    logic [2:0]  csel;
  } cmd_t;

  logic              clk;
  logic              reset;
  logic              ready;
  logic              busy;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_pad;
  logic              cmd_last;
  logic [2:0]        csel;

  int   checks    = 0;
  int   errors    = 0;
  int   n_xfer    = 0;
  int   stall_cnt = 0;
  int   bp_mode   = 1;
  cmd_t exp_q[$];

  conv_sched #(
    .IMG_LOG2 (6),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .busy      (busy),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_pad   (cmd_pad),
    .cmd_last  (cmd_last),
    .csel      (csel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic cmd_t mk(input int op, input int addr, input bit pad, input bit last,
                              input logic [2:0] cs);
    cmd_t c;
    c.op   = 2'(op);
    c.addr = 12'(addr);
    c.pad  = pad;
    c.last = last;
    c.csel = cs;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Full expected command list for one run, straight from the window/raster rules
  task automatic push_model();
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        for (int k = 0; k < 9; k++) begin
          int yy;
          int xx;
          yy = y + k / 3 - 1;
          xx = x + k % 3 - 1;
          if (yy < 0 || yy > 63 || xx < 0 || xx > 63)
            exp_q.push_back(mk(0, 0, 1'b1, k == 8, 3'b000));
          else
            exp_q.push_back(mk(0, yy * 64 + xx, 1'b0, k == 8, 3'b000));
        end
        exp_q.push_back(mk(1, y * 64 + x, 1'b0, 1'b0, 3'b001));
      end
    end
    for (int by = 0; by < 64; by += 2) begin
      for (int bx = 0; bx < 64; bx += 2) begin
        for (int r = 0; r < 4; r++)
          exp_q.push_back(mk(2, (by + r / 2) * 64 + bx + r % 2, 1'b0, r == 3, 3'b001));
        exp_q.push_back(mk(3, (by / 2) * 32 + bx / 2, 1'b0, 1'b0, 3'b011));
      end
    end
  endtask

  // Hand-computed commands at the image corners and the final pool block
  function automatic bit directed(input int idx, output cmd_t c);
    directed = 1'b1;
    c = mk(0, 0, 1'b0, 1'b0, 3'b000);
    case (idx)
      0, 1, 2, 3, 6: c = mk(0, 0, 1'b1, 1'b0, 3'b000);
      4:     c = mk(0, 0, 1'b0, 1'b0, 3'b000);
      5:     c = mk(0, 1, 1'b0, 1'b0, 3'b000);
      7:     c = mk(0, 64, 1'b0, 1'b0, 3'b000);
      8:     c = mk(0, 65, 1'b0, 1'b1, 3'b000);
      9:     c = mk(1, 0, 1'b0, 1'b0, 3'b001);
      40950: c = mk(0, 4030, 1'b0, 1'b0, 3'b000);
      40952, 40955, 40956, 40957: c = mk(0, 0, 1'b1, 1'b0, 3'b000);
      40954: c = mk(0, 4095, 1'b0, 1'b0, 3'b000);
      40958: c = mk(0, 0, 1'b1, 1'b1, 3'b000);
      40959: c = mk(1, 4095, 1'b0, 1'b0, 3'b001);
      40960: c = mk(2, 0, 1'b0, 1'b0, 3'b001);
      40961: c = mk(2, 1, 1'b0, 1'b0, 3'b001);
      40962: c = mk(2, 64, 1'b0, 1'b0, 3'b001);
      40963: c = mk(2, 65, 1'b0, 1'b1, 3'b001);
      46075: c = mk(2, 4030, 1'b0, 1'b0, 3'b001);
      46076: c = mk(2, 4031, 1'b0, 1'b0, 3'b001);
      46077: c = mk(2, 4094, 1'b0, 1'b0, 3'b001);
      46078: c = mk(2, 4095, 1'b0, 1'b1, 3'b001);
      46079: c = mk(3, 1023, 1'b0, 1'b0, 3'b011);
      default: directed = 1'b0;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_op"},    32'(cmd_op),    32'd0);
    check({tag, "_addr"},  32'(cmd_addr),  32'd0);
    check({tag, "_pad"},   32'(cmd_pad),   32'd0);
    check({tag, "_last"},  32'(cmd_last),  32'd0);
    check({tag, "_csel"},  32'(csel),      32'd0);
  endtask

  // Load the expected run, then present ready for one cycle and check start latency
  task automatic start_run(input string tag);
    push_model();
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    check({tag, "_start_busy"},  32'(busy),      32'd1);
    check({tag, "_start_valid"}, 32'(cmd_valid), 32'd1);
  endtask

  // cmd_ready driver: always high, 30% low, or 30% low only near both ends of the run
  initial begin
    cmd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = ($urandom_range(0, 99) >= 30);
        default: cmd_ready = (n_xfer < 3000 || n_xfer > 43000) ? ($urandom_range(0, 99) >= 30) : 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled
  initial begin
    cmd_t cur;
    cmd_t prev_cmd;
    cmd_t e;
    cmd_t d;
    bit   prev_stall;
    prev_stall = 1'b0;
    prev_cmd   = '0;
    forever begin
      @(negedge clk);
      cur.op   = cmd_op;
      cur.addr = cmd_addr;
      cur.pad  = cmd_pad;
      cur.last = cmd_last;
      cur.csel = csel;
      if (!reset) begin
        prev_stall = 1'b0;
        n_xfer     = 0;
        stall_cnt  = 0;
      end else begin
        if (prev_stall)
          check("stall_hold", {12'd0, cmd_valid, cur}, {12'd0, 1'b1, prev_cmd});
        if (!busy) begin
          n_xfer    = 0;
          stall_cnt = 0;
        end
        if (cmd_valid && cmd_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got 0x%0h, expected no further command", cur);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("cmd[%0d]", n_xfer), {13'd0, cur}, {13'd0, e});
          end
          if (directed(n_xfer, d))
            check($sformatf("plan[%0d]", n_xfer), {13'd0, cur}, {13'd0, d});
          n_xfer++;
        end
        prev_stall = cmd_valid && !cmd_ready;
        if (prev_stall) stall_cnt++;
        prev_cmd = cur;
      end
    end
  end

  // Stimulus sequence
  initial begin
    int  edges;
    int  cyc;
    bit  found;
    reset = 1'b0;
    ready = 1'b0;
    bp_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle_valid", 32'(cmd_valid), 32'd0);

    // Run 1: random backpressure, abort with reset during WR_L0 of pixel (10,5)
    start_run("run1");
    found = 1'b0;
    cyc   = 0;
    while (!found && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cmd_valid && cmd_op == 2'd1 && cmd_addr == 12'(5 * 64 + 10)) found = 1'b1;
    end
    check("reach_wr_10_5", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_vals("abort");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Run 2: complete run, backpressure near both ends, ready pulsed mid-run
    bp_mode = 2;
    start_run("run2");
    edges = 0;
    found = 1'b0;
    while (!found && edges < 100000) begin
      @(posedge clk);
      #1;
      edges++;
      ready = (edges == 20000);
      if (!busy) found = 1'b1;
    end
    ready = 1'b0;
    check("run2_busy_fell", 32'(found), 32'd1);
    check("run2_cycles", 32'(edges), 32'(N_CMDS + stall_cnt));
    check("run2_left_in_q", 32'(exp_q.size()), 32'd0);
    check("done_valid", 32'(cmd_valid), 32'd0);
    @(posedge clk);
    #1;
    check("post_done_busy",  32'(busy),      32'd0);
    check("post_done_valid", 32'(cmd_valid), 32'd0);

    // Run 3: second run from IDLE, checked through its opening commands
    bp_mode = 0;
    start_run("run3");
    cyc = 0;
    while (n_xfer < 1000 && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("run3_progress", 32'(n_xfer >= 1000), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_vals("end");
    exp_q.delete();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
